// File: rtl/conv_tx_pkg.sv
// Shared constants and types for the rate-1/2, K=3 convolutional transmitter.
// The symbol width is shared with the decoder's metric arithmetic.
package conv_tx_pkg;

  localparam logic [2:0] G0 = 3'b111;
  localparam logic [2:0] G1 = 3'b101;

  localparam int unsigned N_SYM    = 8;
  localparam int unsigned SYM_W    = 8;
  localparam int unsigned SIGN_BIT = 7;
  localparam logic [2:0]  LAST_IDX = 3'(N_SYM - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_SEND = 2'd2
  } tx_state_e;

  // Modulo-2 sum of the register window taps selected by a generator.
  function automatic logic gen_parity(input logic [2:0] window, input logic [2:0] gen);
    return ^(window & gen);
  endfunction

endpackage

// File: rtl/conv_enc_step.sv
// One trellis step: input bit u and state (s1,s2) give the coded pair and next state.
module conv_enc_step
  import conv_tx_pkg::*;
(
  input  logic       u,
  input  logic [1:0] state,
  output logic       c0,
  output logic       c1,
  output logic [1:0] next_state
);

  logic [2:0] window_s;

  assign window_s   = {u, state};
  assign c0         = gen_parity(window_s, G0);
  assign c1         = gen_parity(window_s, G1);
  assign next_state = {u, state[1]};

endmodule

// File: rtl/conv_encoder_tx.sv
// Encodes a 4-bit word into 8 coded bits and streams them as sign-magnitude
// soft symbols over a valid/ready handshake; all outputs are registered.
module conv_encoder_tx
  import conv_tx_pkg::*;
#(
  parameter logic [6:0] AMP = 7'd16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       data_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SYM_W-1:0] sym_out,
  output logic [2:0]       sym_idx,
  output logic [7:0]       codeword,
  output logic [1:0]       final_state,
  output logic             frame_done
);

  tx_state_e        state_q, state_d;
  logic [3:0]       data_q, data_d;
  logic [1:0]       bit_cnt_q, bit_cnt_d;
  logic [1:0]       enc_state_q, enc_state_d;
  logic [7:0]       codeword_q, codeword_d;
  logic [1:0]       final_state_q, final_state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [SYM_W-1:0] sym_out_q, sym_out_d;
  logic [2:0]       sym_idx_q, sym_idx_d;
  logic             frame_done_q, frame_done_d;

  logic             step_c0_s, step_c1_s;
  logic [1:0]       step_next_s;

  // The info word shifts left so the bit being encoded is always data_q[3].
  conv_enc_step u_step (
    .u          (data_q[3]),
    .state      (enc_state_q),
    .c0         (step_c0_s),
    .c1         (step_c1_s),
    .next_state (step_next_s)
  );

  // Next-state and next-output computation for the IDLE/ENC/SEND sequence.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    bit_cnt_d     = bit_cnt_q;
    enc_state_d   = enc_state_q;
    codeword_d    = codeword_q;
    final_state_d = final_state_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    sym_out_d     = sym_out_q;
    sym_idx_d     = sym_idx_q;
    frame_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d      = data_in;
          enc_state_d = 2'b00;
          bit_cnt_d   = 2'd0;
          in_ready_d  = 1'b0;
          state_d     = ST_ENC;
        end else begin
          in_ready_d  = 1'b1;
        end
      end
      ST_ENC: begin
        data_d      = {data_q[2:0], 1'b0};
        enc_state_d = step_next_s;
        codeword_d  = {codeword_q[5:0], step_c0_s, step_c1_s};
        bit_cnt_d   = bit_cnt_q + 2'd1;
        if (bit_cnt_q == 2'd3) begin
          final_state_d = step_next_s;
          out_valid_d   = 1'b1;
          sym_idx_d     = 3'd0;
          sym_out_d     = {codeword_d[7], AMP};
          state_d       = ST_SEND;
        end else begin
          state_d       = ST_ENC;
        end
      end
      ST_SEND: begin
        // Held symbol/index stay put until downstream takes them.
        if (out_ready) begin
          if (sym_idx_q == LAST_IDX) begin
            out_valid_d  = 1'b0;
            sym_out_d    = 8'h00;
            sym_idx_d    = 3'd0;
            frame_done_d = 1'b1;
            in_ready_d   = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            sym_idx_d    = sym_idx_q + 3'd1;
            sym_out_d    = {codeword_q[3'd6 - sym_idx_q], AMP};
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q       <= ST_IDLE;
      data_q        <= 4'h0;
      bit_cnt_q     <= 2'd0;
      enc_state_q   <= 2'b00;
      codeword_q    <= 8'h00;
      final_state_q <= 2'b00;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      sym_out_q     <= 8'h00;
      sym_idx_q     <= 3'd0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      bit_cnt_q     <= bit_cnt_d;
      enc_state_q   <= enc_state_d;
      codeword_q    <= codeword_d;
      final_state_q <= final_state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      sym_out_q     <= sym_out_d;
      sym_idx_q     <= sym_idx_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign sym_out     = sym_out_q;
  assign sym_idx     = sym_idx_q;
  assign codeword    = codeword_q;
  assign final_state = final_state_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench for conv_encoder_tx: arithmetic encoder model plus a
// frame-level timing model, compared against the DUT on every negedge.
module tb_conv_encoder_tx;

  localparam logic [6:0] AMP = 7'd16;

  logic       CLK;
  logic       RST_N;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sym_out;
  logic [2:0] sym_idx;
  logic [7:0] codeword;
  logic [1:0] final_state;
  logic       frame_done;

  int tests  = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [7:0] acc_q[$];

  conv_encoder_tx #(.AMP(AMP)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .data_in     (data_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sym_out     (sym_out),
    .sym_idx     (sym_idx),
    .codeword    (codeword),
    .final_state (final_state),
    .frame_done  (frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns {codeword, final_state} using mod-2 sums of the shift register taps.
  function automatic logic [9:0] enc_ref(input logic [3:0] d);
    int s1, s2, u, c0, c1;
    logic [7:0] cw;
    s1 = 0; s2 = 0; cw = 8'h00;
    for (int k = 0; k < 4; k++) begin
      u  = int'(d[3-k]);
      c0 = (u + s1 + s2) % 2;
      c1 = (u + s2) % 2;
      cw[7-2*k] = c0[0];
      cw[6-2*k] = c1[0];
      s2 = s1;
      s1 = u;
    end
    return {cw, s1[0], s2[0]};
  endfunction

  // Frame-level timing model: 0 = idle, 1 = encoding, 2 = sending.
  int         m_phase = 0;
  int         m_cnt   = 0;
  int         m_idx   = 0;
  logic [7:0] m_cw    = 8'h00;
  logic [1:0] m_fs    = 2'b00;
  logic [7:0] m_pcw   = 8'h00;
  logic [1:0] m_pfs   = 2'b00;
  logic       m_done  = 1'b0;

  always @(posedge CLK) begin
    if (!RST_N) begin
      m_phase <= 0; m_cnt <= 0; m_idx <= 0;
      m_cw <= 8'h00; m_fs <= 2'b00; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      case (m_phase)
        0: if (in_valid) begin
             m_pcw   <= enc_ref(data_in)[9:2];
             m_pfs   <= enc_ref(data_in)[1:0];
             m_phase <= 1;
             m_cnt   <= 0;
           end
        1: begin
             m_cnt <= m_cnt + 1;
             if (m_cnt == 3) begin
               m_phase <= 2; m_cw <= m_pcw; m_fs <= m_pfs; m_idx <= 0;
             end
           end
        2: if (out_ready) begin
             if (m_idx == 7) begin
               m_phase <= 0; m_done <= 1'b1; m_idx <= 0;
             end else begin
               m_idx <= m_idx + 1;
             end
           end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle compare against the model and capture of accepted symbols.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("out_valid", out_valid, m_phase == 2);
      chk("frame_done", frame_done, m_done);
      if (m_phase != 1) begin
        chk("codeword", codeword, m_cw);
        chk("final_state", final_state, m_fs);
      end
      if (m_phase == 2) begin
        chk("sym_idx", sym_idx, m_idx);
        chk("sym_out", sym_out, {m_cw[7-m_idx], AMP});
      end
      if (out_valid && out_ready) acc_q.push_back(sym_out);
    end
  end

  task automatic check_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sym_out", sym_out, 8'h00);
    chk("rst_sym_idx", sym_idx, 0);
    chk("rst_codeword", codeword, 8'h00);
    chk("rst_final_state", final_state, 0);
    chk("rst_frame_done", frame_done, 0);
  endtask

  task automatic wait_in_ready();
    int budget = 0;
    while (!in_ready && budget < 50) begin
      @(posedge CLK); #1; budget++;
    end
    chk("in_ready_timeout", budget < 50, 1);
  endtask

  task automatic send_frame(input logic [3:0] d, input int stall_at, input int stall_len,
                            input bit junk, input bit rnd_ready);
    logic [7:0] cw;
    int cyc, stalled;
    bit done;
    cw = enc_ref(d)[9:2];
    wait_in_ready();
    acc_q.delete();
    in_valid = 1'b1; data_in = d; out_ready = 1'b1;
    @(posedge CLK); #1;
    cyc = 1; stalled = 0; done = 1'b0;
    if (junk) data_in = ~d;
    else in_valid = 1'b0;
    while (!done && cyc < 80) begin
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      else if (out_valid && int'(sym_idx) == stall_at && stalled < stall_len) begin
        out_ready = 1'b0; stalled++;
      end else out_ready = 1'b1;
      @(posedge CLK); #1; cyc++;
      if (frame_done) done = 1'b1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("frame_done_seen", done, 1);
    if (!rnd_ready) chk("done_latency", cyc, 13 + stall_len);
    chk("sym_count", acc_q.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < acc_q.size()) chk("sym_seq", acc_q[k], {cw[7-k], AMP});
  endtask

  logic [7:0] exp_1011 [8] = '{8'h90, 8'h90, 8'h90, 8'h10, 8'h10, 8'h10, 8'h10, 8'h90};

  initial begin
    int budget;
    logic [3:0] rd;
    RST_N = 1'b0; in_valid = 1'b0; data_in = 4'h0; out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals();
    chk_en = 1'b1;
    RST_N = 1'b1;

    // Pin the reference encoder to hand-computed codewords.
    chk("model_1011", enc_ref(4'b1011), {8'hE1, 2'b11});
    chk("model_1000", enc_ref(4'b1000), {8'hEC, 2'b00});
    chk("model_0000", enc_ref(4'b0000), {8'h00, 2'b00});

    send_frame(4'b1011, -1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      if (k < acc_q.size()) chk("lit_1011_sym", acc_q[k], exp_1011[k]);
    chk("lit_1011_cw", codeword, 8'hE1);
    chk("lit_1011_fs", final_state, 2'b11);

    send_frame(4'b0000, -1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++)
      if (k < acc_q.size()) chk("lit_0000_sym", acc_q[k], 8'h10);
    chk("lit_0000_cw", codeword, 8'h00);

    send_frame(4'b1000, -1, 0, 1'b0, 1'b0);
    chk("lit_1000_cw", codeword, 8'hEC);
    chk("lit_1000_fs", final_state, 2'b00);

    send_frame(4'b0110, 3, 3, 1'b0, 1'b0);
    send_frame(4'b1101, -1, 0, 1'b1, 1'b0);
    chk("junk_cw", codeword, enc_ref(4'b1101)[9:2]);

    // Reset pulse during SEND at index 5 aborts the frame.
    wait_in_ready();
    in_valid = 1'b1; data_in = 4'b1011; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    budget = 0;
    while (!(out_valid && sym_idx == 3'd5) && budget < 40) begin
      @(posedge CLK); #1; budget++;
    end
    chk("reach_idx5", budget < 40, 1);
    RST_N = 1'b0;
    @(posedge CLK); #1;
    check_reset_vals();
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("no_done_after_abort", frame_done, 0);
    send_frame(4'b1000, -1, 0, 1'b0, 1'b0);
    chk("post_rst_cw", codeword, 8'hEC);

    for (int n = 0; n < 20; n++) begin
      rd = 4'($urandom_range(0, 15));
      send_frame(rd, -1, 0, 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/conv_encoder_tx.md
# conv_encoder_tx

Transmit-side counterpart of the team's 4-state soft-decision Viterbi decoder. The block accepts a 4-bit information word and convolutionally encodes it, one bit per cycle, with a rate-1/2, K=3 code (generators 7/5 octal, start state 00, no tail). It maps the resulting 8 coded bits to 8-bit sign-magnitude soft symbols and streams them out with a valid/ready handshake. Its symbol order and codeword packing are exactly what the decoder pipeline consumes as r1..r8 and compares against its decoded codeword.

## Interface
Parameters:
- AMP, 7'd16, magnitude of every transmitted symbol (sign-magnitude, noiseless).

Ports:
- CLK  input  1  single clock; all state updates on posedge CLK.
- RST_N  input  1  reset, synchronous, active-low.
- in_valid  input  1  data_in is presented.
- in_ready  output  1  block can accept a word; high only in IDLE.
- data_in  input  4  information bits; data_in[3] is encoded first.
- out_valid  output  1  sym_out and sym_idx are valid.
- out_ready  input  1  downstream accepts the current symbol.
- sym_out  output  8  soft symbol {sign, AMP}. Coded 0 gives sign 0 (+AMP); coded 1 gives sign 1 (-AMP).
- sym_idx  output  3  symbol index 0..7 (r1..r8).
- codeword  output  8  packed coded bits of the current/last frame.
- final_state  output  2  encoder state after the 4th info bit.
- frame_done  output  1  one-cycle pulse after the last symbol is accepted.

## Operation
- FSM states: IDLE, ENC, SEND.
- IDLE: in_ready=1. On in_valid: latch data_in, clear enc_state to 00, clear bit counter, go to ENC.
- ENC: runs 4 cycles, one info bit u per cycle, MSB first. With state (s1,s2):
  - c0 = u^s1^s2, c1 = u^s2.
  - Next state is (u,s1).
  - Each pair is shifted in from the LSB end, so the pair for bit k lands at codeword[7-2k:6-2k], with c0 in the higher position.
  - After the 4th bit, final_state = (s1,s2) and the FSM goes to SEND.
- SEND: out_valid=1.
  - sym_out = {codeword[7-sym_idx], AMP}.
  - sym_idx advances only on out_valid && out_ready.
  - On acceptance at sym_idx=7: pulse frame_done, go to IDLE.
- codeword and final_state hold until the next frame's ENC begins; they are the only frame results visible in IDLE.
- Backpressure: while out_valid && !out_ready, sym_out and sym_idx are held stable.
- No sym_idx wrap: index 7 is followed by IDLE, not index 0.
- in_valid outside IDLE is ignored, and in_ready=0 there.
- Reset while RST_N=0 (including mid-frame): all outputs go to reset values and the FSM returns to IDLE. The aborted frame produces no frame_done.

## Timing
- Reset values:
  - in_ready=1 from the first cycle after reset.
  - out_valid=0, sym_out=8'h00, sym_idx=0.
  - codeword=8'h00, final_state=2'b00, frame_done=0.
- Accept at edge T. ENC occupies T+1..T+4. out_valid rises after edge T+4 (first visible in cycle T+5).
- With out_ready held high: 8 symbols are presented over 8 consecutive cycles, and frame_done is high for the one cycle after the edge that accepts sym_idx=7.
- in_ready rises in that same cycle, so there are 13 cycles from accept to next-accept at full throughput.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package conv_tx_pkg holds:
  - G0=3'b111 and G1=3'b101.
  - The FSM state enum.
  - The symbol-count constant 8.
  - The sign-magnitude width (8, sign at bit 7). The decoder's metric arithmetic shares this width.
- Sub-module conv_enc_step: combinational single trellis step, (u, state[1:0]) to (c0, c1, next_state). The top instantiates it once and registers its outputs.

## Test plan
- data_in=4'b1011, out_ready=1 gives codeword=8'hE1 and final_state=2'b11. sym_out sequence: 90,90,90,10,10,10,10,90.
- data_in=4'b0000 gives codeword=8'h00 and final_state=00. All eight sym_out=8'h10; frame_done appears 13 cycles after accept.
- data_in=4'b1000 gives codeword=8'hEC and final_state=00. Loopback into the Viterbi decoder chain yields decoded codeword 8'hEC.
- Drop out_ready for 3 cycles at sym_idx=3: sym_out and sym_idx stay frozen, no symbol is skipped or duplicated, and frame_done is delayed by exactly 3 cycles.
- Pulse RST_N low for 1 cycle during SEND at sym_idx=5: all outputs return to reset values, there is no frame_done, and the next frame encodes correctly from state 00.
- Assert in_valid with a new word during ENC and SEND: it is ignored, and the current frame's codeword is unchanged.
